// File: rtl/conv_job_sched.sv
// Round-robin scheduler sharing one convolution engine among NUM_REQ requesters.
// Optional RUN timeout is enabled with `define CONV_SCHED_TIMEOUT_EN.
module conv_job_sched #(
    parameter int NUM_REQ    = 4,
    parameter int IDW        = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     eng_sel,
    output logic               eng_rst,
    input  logic               eng_done,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_err,
    output logic               busy,
    output logic [15:0]        job_count
);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [IDW-1:0]     sel_r, sel_nxt_s, ptr_r, ptr_nxt_s, pick_idx_s;
    logic               eng_rst_r, eng_rst_nxt_s;
    logic               rsp_valid_r, rsp_valid_nxt_s;
    logic               rsp_err_nxt_s;
    logic               busy_r;
    logic [15:0]        job_r, job_nxt_s;
    logic [CW-1:0]      clr_cnt_r, clr_cnt_nxt_s;
    logic               pick_found_s;
    logic [IDW:0]       cand_s;
    logic               timeout_hit_s;
    logic               clr_last_s;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] run_cnt_r, run_cnt_nxt_s;
    logic          rsp_err_r;
    assign timeout_hit_s = (run_cnt_r == TW'(TIMEOUT - 1));
    assign rsp_err       = rsp_err_r;

    // RUN-cycle counter and latched timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_r <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            run_cnt_r <= run_cnt_nxt_s;
            rsp_err_r <= rsp_err_nxt_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    assign clr_last_s = (clr_cnt_r == CW'(CLR_CYCLES - 1));

    // Round-robin search starting one past the last granted index
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (cand_s >= (IDW+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDW+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && req[cand_s[IDW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[IDW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= '0;
            sel_r       <= '0;
            ptr_r       <= IDW'(NUM_REQ - 1);
            eng_rst_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            job_r       <= 16'd0;
            clr_cnt_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            sel_r       <= sel_nxt_s;
            ptr_r       <= ptr_nxt_s;
            eng_rst_r   <= eng_rst_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            job_r       <= job_nxt_s;
            clr_cnt_r   <= clr_cnt_nxt_s;
        end
    end

    // Next-state decode; eng_done wins over a same-cycle timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = pick_found_s ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nxt_s = clr_last_s ? ST_RUN : ST_CLEAR;
            ST_RUN:   state_nxt_s = (eng_done || timeout_hit_s) ? ST_RESP : ST_RUN;
            ST_RESP:  state_nxt_s = (rsp_valid_r && rsp_ready) ? ST_IDLE : ST_RESP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        gnt_nxt_s       = gnt_r;
        sel_nxt_s       = sel_r;
        ptr_nxt_s       = ptr_r;
        eng_rst_nxt_s   = eng_rst_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_err_nxt_s   = rsp_err;
        job_nxt_s       = job_r;
        clr_cnt_nxt_s   = clr_cnt_r;
`ifdef CONV_SCHED_TIMEOUT_EN
        run_cnt_nxt_s   = run_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                eng_rst_nxt_s = 1'b0;
                if (pick_found_s) begin
                    gnt_nxt_s     = NUM_REQ'(1'b1) << pick_idx_s;
                    sel_nxt_s     = pick_idx_s;
                    ptr_nxt_s     = pick_idx_s;
                    clr_cnt_nxt_s = '0;
                end else begin
                    gnt_nxt_s     = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    eng_rst_nxt_s = 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
                    run_cnt_nxt_s = '0;
`endif
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + CW'(1);
                end
            end
            ST_RUN: begin
                if (eng_done) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b0;
                end else if (timeout_hit_s) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b1;
                end else begin
`ifdef CONV_SCHED_TIMEOUT_EN
                    run_cnt_nxt_s   = run_cnt_r + TW'(1);
`endif
                    rsp_valid_nxt_s = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    gnt_nxt_s       = '0;
                    rsp_valid_nxt_s = 1'b0;
                    rsp_err_nxt_s   = 1'b0;
                    eng_rst_nxt_s   = 1'b0;
                    job_nxt_s       = job_r + 16'd1;
                end else begin
                    rsp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                gnt_nxt_s       = '0;
                rsp_valid_nxt_s = 1'b0;
                eng_rst_nxt_s   = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_r;
    assign eng_sel   = sel_r;
    assign eng_rst   = eng_rst_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign job_count = job_r;

endmodule
